// File: rtl/md_stream_merge.sv
// rtl/md_stream_merge.sv - packet-granular round-robin 2:1 merger of metadata streams
//
// Interleaves whole packets from two TLAST-framed metadata streams onto one
// registered output stream. A packet, once started, owns the output until
// its TLAST beat is accepted. TID tags every output beat with its source.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   AXIS_IN_MD1_*                input stream #1 (TDATA/TVALID/TREADY/TLAST)
//   AXIS_IN_MD2_*                input stream #2 (TDATA/TVALID/TREADY/TLAST)
//   AXIS_OUT_MD_*                merged output (TDATA/TVALID/TREADY/TLAST/TID)
//   PKT_CNT1, PKT_CNT2           wrapping counts of TLAST beats accepted per input
module md_stream_merge #(
    parameter int DW    = 512,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DW-1:0]    AXIS_IN_MD1_TDATA,
    input  logic             AXIS_IN_MD1_TVALID,
    output logic             AXIS_IN_MD1_TREADY,
    input  logic             AXIS_IN_MD1_TLAST,
    input  logic [DW-1:0]    AXIS_IN_MD2_TDATA,
    input  logic             AXIS_IN_MD2_TVALID,
    output logic             AXIS_IN_MD2_TREADY,
    input  logic             AXIS_IN_MD2_TLAST,
    output logic [DW-1:0]    AXIS_OUT_MD_TDATA,
    output logic             AXIS_OUT_MD_TVALID,
    input  logic             AXIS_OUT_MD_TREADY,
    output logic             AXIS_OUT_MD_TLAST,
    output logic             AXIS_OUT_MD_TID,
    output logic [CNT_W-1:0] PKT_CNT1,
    output logic [CNT_W-1:0] PKT_CNT2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2
    } state_t;

    state_t state_q, state_d;

    // 0 = MD1, 1 = MD2; reset to MD2 so MD1 wins the first tie
    logic last_grant_q;

    logic          slot_free;
    logic          grant_en;   // some input is granted this cycle
    logic          grant_sel;  // which input is granted (0 = MD1, 1 = MD2)
    logic          accept;     // granted input handshakes this cycle
    logic          beat_last;
    logic [DW-1:0] beat_data;

    assign slot_free = !AXIS_OUT_MD_TVALID || AXIS_OUT_MD_TREADY;

    always_comb begin
        state_d   = state_q;
        grant_en  = 1'b0;
        grant_sel = 1'b0;
        case (state_q)
            IDLE: begin
                // Grant depends on TVALID only here; mid-packet the owner is fixed
                if (AXIS_IN_MD1_TVALID && AXIS_IN_MD2_TVALID) begin
                    grant_en  = 1'b1;
                    grant_sel = ~last_grant_q;
                end else if (AXIS_IN_MD1_TVALID) begin
                    grant_en  = 1'b1;
                    grant_sel = 1'b0;
                end else if (AXIS_IN_MD2_TVALID) begin
                    grant_en  = 1'b1;
                    grant_sel = 1'b1;
                end
            end
            PASS1: begin
                grant_en  = 1'b1;
                grant_sel = 1'b0;
            end
            PASS2: begin
                grant_en  = 1'b1;
                grant_sel = 1'b1;
            end
            default: begin
                grant_en  = 1'b0;
                grant_sel = 1'b0;
            end
        endcase

        AXIS_IN_MD1_TREADY = grant_en && !grant_sel && slot_free;
        AXIS_IN_MD2_TREADY = grant_en &&  grant_sel && slot_free;

        accept    = grant_sel ? (AXIS_IN_MD2_TVALID && AXIS_IN_MD2_TREADY)
                              : (AXIS_IN_MD1_TVALID && AXIS_IN_MD1_TREADY);
        beat_last = grant_sel ? AXIS_IN_MD2_TLAST : AXIS_IN_MD1_TLAST;
        beat_data = grant_sel ? AXIS_IN_MD2_TDATA : AXIS_IN_MD1_TDATA;

        if (accept) begin
            if (state_q == IDLE) begin
                if (!beat_last) begin
                    state_d = grant_sel ? PASS2 : PASS1;
                end
            end else if (beat_last) begin
                // Re-entering IDLE lets the next grant happen the following cycle
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q            <= IDLE;
            last_grant_q       <= 1'b1;
            AXIS_OUT_MD_TVALID <= 1'b0;
            AXIS_OUT_MD_TDATA  <= '0;
            AXIS_OUT_MD_TLAST  <= 1'b0;
            AXIS_OUT_MD_TID    <= 1'b0;
            PKT_CNT1           <= '0;
            PKT_CNT2           <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q       <= grant_sel;
                AXIS_OUT_MD_TVALID <= 1'b1;
                AXIS_OUT_MD_TDATA  <= beat_data;
                AXIS_OUT_MD_TLAST  <= beat_last;
                AXIS_OUT_MD_TID    <= grant_sel;
                if (beat_last) begin
                    if (grant_sel) begin
                        PKT_CNT2 <= PKT_CNT2 + CNT_W'(1);
                    end else begin
                        PKT_CNT1 <= PKT_CNT1 + CNT_W'(1);
                    end
                end
            end else if (AXIS_OUT_MD_TREADY) begin
                AXIS_OUT_MD_TVALID <= 1'b0;
            end
        end
    end

endmodule
